// File: rtl/sobel_window_gen_if.sv
// sobel_window_gen_if
// Bundles the pixel input stream and the 3x3 window output of sobel_window_gen.
//
// Handshake: pix_valid qualifies pix_in (and sof_in when present) for exactly
// the cycle it is high; there is no ready, so the consumer of pixels must take
// every valid beat. win_valid likewise qualifies p*/win_last for one cycle, with
// no backpressure from downstream.
//
// Signals:
//   pix_in[7:0]   pixel from the raster source
//   pix_valid     pix_in is presented this cycle
//   sof_in        start of frame (only with SOBEL_SOF_RESYNC_EN defined)
//   p0..p8[8:0]   window taps (p4 absent), zero-extended to 9 bits
//   win_valid     window on p* is valid this cycle
//   win_last      final window of the frame
//   state_dbg     window FSM state (0 = filling rows 0-1, 1 = running)
//
// Modports: master = pixel source / window sink, slave = sobel_window_gen.
// Optional macro: SOBEL_SOF_RESYNC_EN adds sof_in.
interface sobel_window_gen_if;
  logic [7:0] pix_in;
  logic       pix_valid;
`ifdef SOBEL_SOF_RESYNC_EN
  logic       sof_in;
`endif
  logic [8:0] p0, p1, p2, p3, p5, p6, p7, p8;
  logic       win_valid;
  logic       win_last;
  logic       state_dbg;

`ifdef SOBEL_SOF_RESYNC_EN
  modport master (
    output pix_in, pix_valid, sof_in,
    input  p0, p1, p2, p3, p5, p6, p7, p8, win_valid, win_last, state_dbg
  );
  modport slave (
    input  pix_in, pix_valid, sof_in,
    output p0, p1, p2, p3, p5, p6, p7, p8, win_valid, win_last, state_dbg
  );
`else
  modport master (
    output pix_in, pix_valid,
    input  p0, p1, p2, p3, p5, p6, p7, p8, win_valid, win_last, state_dbg
  );
  modport slave (
    input  pix_in, pix_valid,
    output p0, p1, p2, p3, p5, p6, p7, p8, win_valid, win_last, state_dbg
  );
`endif
endinterface

// File: rtl/sobel_window_gen.sv
// sobel_window_gen
// Raster-to-3x3-window producer for the sobel edge core. Accepts one 8-bit
// pixel per valid cycle in raster order, keeps the two previous lines in line
// buffers and emits the eight neighbourhood taps (no centre tap) one cycle
// after the pixel that completes a window. No border padding: windows exist
// only for rows >= 2 and columns >= 2.
//
// Ports:
//   clk      clock, all state on posedge
//   rst      asynchronous, active-high reset
//   win_if   sobel_window_gen_if.slave (pixel stream in, window out)
//
// Parameters: IMG_W, IMG_H (>= 3), COL_W / ROW_W counter widths.
// Optional macro: SOBEL_SOF_RESYNC_EN -- an accepted pixel with sof_in high is
// forced to position (0,0) and the FSM restarts in S_FILL.
module sobel_window_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int COL_W = 10,
  parameter int ROW_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  sobel_window_gen_if.slave win_if
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d, eff_state;
  logic [COL_W-1:0] col_q, col_d, eff_col;
  logic [ROW_W-1:0] row_q, row_d, eff_row;

  // lb0 holds row r-1, lb1 holds row r-2. Not reset: rows 0-1 of every frame
  // overwrite them before any window can read them.
  logic [7:0] lb0_mem [IMG_W];
  logic [7:0] lb1_mem [IMG_W];
  logic [7:0] lb0_rd, lb1_rd;

  // Column history per window row. The newest column of each row comes straight
  // from the line-buffer reads / pix_in, so two stored columns complete the
  // three-wide window.
  logic [1:0][7:0] top_q, top_d;
  logic [1:0][7:0] mid_q, mid_d;
  logic [1:0][7:0] bot_q, bot_d;

  logic [8:0] p0_q, p1_q, p2_q, p3_q, p5_q, p6_q, p7_q, p8_q;
  logic [8:0] p0_d, p1_d, p2_d, p3_d, p5_d, p6_d, p7_d, p8_d;
  logic       win_valid_q, win_valid_d;
  logic       win_last_q, win_last_d;

  logic accept;
  logic sof;
  logic col_last, row_last, emit;

  assign accept = win_if.pix_valid;

`ifdef SOBEL_SOF_RESYNC_EN
  // sof_in only counts on an accepted beat.
  assign sof = win_if.pix_valid & win_if.sof_in;
`else
  assign sof = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    top_d       = top_q;
    mid_d       = mid_q;
    bot_d       = bot_q;
    p0_d        = p0_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    p3_d        = p3_q;
    p5_d        = p5_q;
    p6_d        = p6_q;
    p7_d        = p7_q;
    p8_d        = p8_q;
    win_valid_d = 1'b0;
    win_last_d  = 1'b0;

    // Position of the pixel on the bus this cycle; a resync pixel is (0,0)
    // in a fresh S_FILL regardless of where the counters were.
    eff_col   = sof ? '0 : col_q;
    eff_row   = sof ? '0 : row_q;
    eff_state = sof ? S_FILL : state_q;

    // Asynchronous reads see the old contents: read-before-write.
    lb0_rd = lb0_mem[eff_col];
    lb1_rd = lb1_mem[eff_col];

    col_last = (eff_col == COL_MAX);
    row_last = (eff_row == ROW_MAX);
    emit     = accept && (eff_state == S_RUN) && (eff_col >= COL_W'(2));

    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : eff_row + ROW_W'(1);
      end else begin
        col_d = eff_col + COL_W'(1);
        row_d = eff_row;
      end

      state_d = eff_state;
      if (eff_state == S_FILL && eff_row == ROW_W'(1) && col_last) begin
        state_d = S_RUN;
      end else if (eff_state == S_RUN && row_last && col_last) begin
        state_d = S_FILL;
      end

      top_d = {top_q[0], lb1_rd};
      mid_d = {mid_q[0], lb0_rd};
      bot_d = {bot_q[0], win_if.pix_in};
    end

    if (emit) begin
      win_valid_d = 1'b1;
      win_last_d  = row_last && col_last;
      p0_d = {1'b0, top_q[1]};
      p1_d = {1'b0, top_q[0]};
      p2_d = {1'b0, lb1_rd};
      p3_d = {1'b0, mid_q[1]};
      p5_d = {1'b0, lb0_rd};
      p6_d = {1'b0, bot_q[1]};
      p7_d = {1'b0, bot_q[0]};
      p8_d = {1'b0, win_if.pix_in};
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_mem[eff_col] <= lb0_mem[eff_col];
      lb0_mem[eff_col] <= win_if.pix_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FILL;
      col_q       <= '0;
      row_q       <= '0;
      top_q       <= '0;
      mid_q       <= '0;
      bot_q       <= '0;
      p0_q        <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      p3_q        <= '0;
      p5_q        <= '0;
      p6_q        <= '0;
      p7_q        <= '0;
      p8_q        <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      top_q       <= top_d;
      mid_q       <= mid_d;
      bot_q       <= bot_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      p3_q        <= p3_d;
      p5_q        <= p5_d;
      p6_q        <= p6_d;
      p7_q        <= p7_d;
      p8_q        <= p8_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
    end
  end

  assign win_if.p0        = p0_q;
  assign win_if.p1        = p1_q;
  assign win_if.p2        = p2_q;
  assign win_if.p3        = p3_q;
  assign win_if.p5        = p5_q;
  assign win_if.p6        = p6_q;
  assign win_if.p7        = p7_q;
  assign win_if.p8        = p8_q;
  assign win_if.win_valid = win_valid_q;
  assign win_if.win_last  = win_last_q;
  assign win_if.state_dbg = (state_q == S_RUN);

endmodule

// File: tb/tb_sobel_window_gen.sv
module tb_sobel_window_gen;

  localparam int IMG_W = 8;
  localparam int IMG_H = 6;
  localparam int COL_W = 3;
  localparam int ROW_W = 3;
  localparam int NWIN  = (IMG_W - 2) * (IMG_H - 2);

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  sobel_window_gen_if tb_if ();

  sobel_window_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .win_if (tb_if)
  );

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_errors = 0;

  // Expected window: {last, p0, p1, p2, p3, p5, p6, p7, p8} as 8-bit pixels.
  logic [64:0] exp_q[$];
  bit          exp_flag;
  logic [63:0] held;

  logic [7:0] img [IMG_H][IMG_W];
  int mr, mc;

  int win_cnt, last_cnt;
  logic [71:0] obs_log[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] tap(input logic [71:0] w, input int i);
    return w[71 - 9*i -: 9];
  endfunction

  // Sees the outputs registered at the previous posedge.
  task automatic check_outputs();
    logic [64:0] w;
    logic [71:0] o;
    w = '0;
    chk("win_valid", 32'(tb_if.win_valid), 32'(exp_flag));
    if (exp_flag) begin
      w = exp_q.pop_front();
      held = w[63:0];
    end
    chk("win_last", 32'(tb_if.win_last), 32'(exp_flag & w[64]));
    chk("p0", 32'(tb_if.p0), {24'd0, held[63:56]});
    chk("p1", 32'(tb_if.p1), {24'd0, held[55:48]});
    chk("p2", 32'(tb_if.p2), {24'd0, held[47:40]});
    chk("p3", 32'(tb_if.p3), {24'd0, held[39:32]});
    chk("p5", 32'(tb_if.p5), {24'd0, held[31:24]});
    chk("p6", 32'(tb_if.p6), {24'd0, held[23:16]});
    chk("p7", 32'(tb_if.p7), {24'd0, held[15:8]});
    chk("p8", 32'(tb_if.p8), {24'd0, held[7:0]});
    if (tb_if.win_valid === 1'b1) begin
      o = {tb_if.p0, tb_if.p1, tb_if.p2, tb_if.p3, tb_if.p5, tb_if.p6, tb_if.p7, tb_if.p8};
      obs_log.push_back(o);
      win_cnt++;
      if (tb_if.win_last === 1'b1) last_cnt++;
    end
    exp_flag = 1'b0;
  endtask

  // Reference model: place the pixel in a 2-D frame image and, when a full
  // 3x3 neighbourhood exists, queue the window it completes.
  task automatic model_accept(input logic [7:0] val, input bit s);
    if (s) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc] = val;
    if (mr >= 2 && mc >= 2) begin
      exp_q.push_back({(mr == IMG_H-1 && mc == IMG_W-1),
                       img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                       img[mr-1][mc-2], img[mr-1][mc],
                       img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]});
      exp_flag = 1'b1;
    end
    mc++;
    if (mc == IMG_W) begin
      mc = 0;
      mr = (mr == IMG_H-1) ? 0 : mr + 1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit v, input logic [7:0] val, input bit s);
    @(negedge clk);
    check_outputs();
    tb_if.pix_valid = v;
    tb_if.pix_in    = val;
`ifdef SOBEL_SOF_RESYNC_EN
    tb_if.sof_in    = s;
`endif
    if (v) model_accept(val, s);
  endtask

  task automatic do_reset(input bit check_first);
    @(negedge clk);
    if (check_first) check_outputs();
    tb_if.pix_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_win_valid", 32'(tb_if.win_valid), 32'd0);
    chk("rst_win_last",  32'(tb_if.win_last),  32'd0);
    chk("rst_p0", 32'(tb_if.p0), 32'd0);
    chk("rst_p5", 32'(tb_if.p5), 32'd0);
    chk("rst_p8", 32'(tb_if.p8), 32'd0);
    chk("rst_state", 32'(tb_if.state_dbg), 32'd0);
    mr = 0;
    mc = 0;
    exp_q.delete();
    exp_flag = 1'b0;
    held = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [7:0] pix_val(input int mode, input int r, input int c);
    case (mode)
      0:       return 8'(r*16 + c);
      1:       return 8'(255 - (r*16 + c));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // gap: 0 = continuous, 1 = every other cycle + 20-cycle gap in row 3,
  // 2 = random idle cycles.
  task automatic send_frame(input int mode, input int gap, input bit sof_first);
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        if (gap == 1) begin
          step(1'b0, 8'd0, 1'b0);
          if (r == 3 && c == 4) begin
            for (int g = 0; g < 20; g++) step(1'b0, 8'd0, 1'b0);
          end
        end else if (gap == 2) begin
          for (int g = 0; g < int'($urandom_range(0, 3)); g++) step(1'b0, 8'd0, 1'b0);
        end
        step(1'b1, pix_val(mode, r, c), sof_first && r == 0 && c == 0);
      end
    end
  endtask

  task automatic drain();
    step(1'b0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 1'b0);
  endtask

  task automatic clear_counts();
    win_cnt  = 0;
    last_cnt = 0;
    obs_log.delete();
  endtask

  task automatic chk_first_sc1(input string tag, input int idx);
    int exp_taps[8];
    exp_taps = '{0, 1, 2, 16, 18, 32, 33, 34};
    if (obs_log.size() <= idx) begin
      chk({tag, "_present"}, 32'(obs_log.size()), 32'(idx + 1));
    end else begin
      for (int i = 0; i < 8; i++) chk(tag, 32'(tap(obs_log[idx], i)), 32'(exp_taps[i]));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int exp_last[8];
    rst = 1'b0;
    tb_if.pix_valid = 1'b0;
    tb_if.pix_in    = '0;
`ifdef SOBEL_SOF_RESYNC_EN
    tb_if.sof_in    = 1'b0;
`endif
    exp_flag = 1'b0;
    held = '0;
    mr = 0;
    mc = 0;
    do_reset(1'b0);

    // Scenarios 1/2: one continuous frame.
    clear_counts();
    send_frame(0, 0, 1'b0);
    drain();
    chk("sc1_win_count", 32'(win_cnt), 32'(NWIN));
    chk("sc1_last_count", 32'(last_cnt), 32'd1);
    chk_first_sc1("sc1_first", 0);
    exp_last = '{53, 54, 55, 69, 71, 85, 86, 87};
    if (obs_log.size() == NWIN) begin
      for (int i = 0; i < 8; i++) chk("sc2_last", 32'(tap(obs_log[NWIN-1], i)), 32'(exp_last[i]));
    end

    // Scenario 3: sparse valid with a long gap.
    clear_counts();
    send_frame(0, 1, 1'b0);
    drain();
    chk("sc3_win_count", 32'(win_cnt), 32'(NWIN));

    // Scenario 4: two frames back to back.
    clear_counts();
    send_frame(0, 0, 1'b0);
    send_frame(1, 0, 1'b0);
    drain();
    chk("sc4_win_count", 32'(win_cnt), 32'(2 * NWIN));
    chk("sc4_last_count", 32'(last_cnt), 32'd2);
    if (obs_log.size() > NWIN) begin
      chk("sc4_f2_p0", 32'(tap(obs_log[NWIN], 0)), 32'd255);
      chk("sc4_f2_p8", 32'(tap(obs_log[NWIN], 7)), 32'd221);
    end

    // Scenario 5: reset mid-frame after 30 pixels.
    for (int i = 0; i < 30; i++) step(1'b1, pix_val(0, i / IMG_W, i % IMG_W), 1'b0);
    do_reset(1'b1);
    clear_counts();
    send_frame(0, 0, 1'b0);
    drain();
    chk("sc5_win_count", 32'(win_cnt), 32'(NWIN));
    chk_first_sc1("sc5_first", 0);

`ifdef SOBEL_SOF_RESYNC_EN
    // Scenario 6: orphan pixels, then a frame opened with sof_in.
    clear_counts();
    for (int i = 0; i < 13; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    send_frame(0, 0, 1'b1);
    drain();
    chk("sc6_win_count", 32'(win_cnt), 32'(NWIN));
    chk_first_sc1("sc6_first", 0);
    // Abort a frame deep in S_RUN, then resync.
    clear_counts();
    for (int i = 0; i < 35; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    send_frame(2, 2, 1'b1);
    drain();
    chk("sc6b_last_count", 32'(last_cnt), 32'd1);
`endif

    // Random frames with random gaps.
    clear_counts();
    for (int f = 0; f < 4; f++) send_frame(2, 2, 1'b0);
    drain();
    chk("rand_win_count", 32'(win_cnt), 32'(4 * NWIN));
    chk("rand_last_count", 32'(last_cnt), 32'd4);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
Raster-to-window producer that feeds the sobel edge core. It accepts one 8-bit pixel per cycle in raster order and buffers two previous image lines in internal line buffers. It emits the eight 3x3 neighbourhood taps p0,p1,p2,p3,p5,p6,p7,p8 (centre p4 is not used) as 9-bit zero-extended values, plus a valid strobe. Sits directly upstream of sobel; its outputs wire port-for-port onto sobel's p* inputs.

Parameters:
IMG_W, 640, pixels per line (>=3)
IMG_H, 480, lines per frame (>=3)
COL_W, 10, column counter width (2^COL_W >= IMG_W)
ROW_W, 9, row counter width (2^ROW_W >= IMG_H)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  reset; asynchronous, active-high
pix_in  in  8  input pixel
pix_valid  in  1  pix_in accepted this cycle when high; no backpressure
sof_in  in  1  start of frame, qualified by pix_valid (present only with SOBEL_SOF_RESYNC_EN)
p0,p1,p2  out  9  top row of window, left to right
p3,p5  out  9  middle row, left and right
p6,p7,p8  out  9  bottom row, left to right
win_valid  out  1  window on p* is valid this cycle
win_last  out  1  final window of frame; only high together with win_valid

Behaviour:
- Reset values: all p* = 0, win_valid = 0, win_last = 0, col = 0, row = 0, FSM = S_FILL. Line buffer RAM is not cleared.
- Counters: col advances on every accepted pixel. At IMG_W-1 it wraps to 0 and row increments. When row = IMG_H-1 and col = IMG_W-1, both wrap to 0 (next frame).
- Line buffers: lb0 holds row r-1, lb1 holds row r-2, each IMG_W x 8. On accept at column c, read lb0[c] and lb1[c], then write lb1[c] <= lb0[c] and lb0[c] <= pix_in in the same cycle. Reads are read-before-write.
- Window shift: three 3-deep column shift registers load on accept. Top row loads lb1[c], middle loads lb0[c], bottom loads pix_in. No shift when pix_valid = 0.
- Tap mapping for an accepted pixel (r,c): p8=(r,c), p7=(r,c-1), p6=(r,c-2), p5=(r-1,c), p3=(r-1,c-2), p2=(r-2,c), p1=(r-2,c-1), p0=(r-2,c-2). Bit 8 of every p* is always 0.
- FSM:
  - S_FILL covers rows 0-1. On the accept of the last pixel of row 1, go to S_RUN.
  - S_RUN covers rows 2..IMG_H-1. On the accept of the last pixel of the frame, go to S_FILL.
- Emission: a window is emitted only in S_RUN for an accepted pixel with c >= 2. No border padding, so windows never span a row wrap.
  - Exactly (IMG_W-2)*(IMG_H-2) windows per frame.
- Latency: p* and win_valid are registered. win_valid = 1 exactly one cycle after the completing pixel is accepted; otherwise 0.
  - When win_valid = 0, p* hold their last values.
- win_last = 1 with the window for pixel (IMG_H-1, IMG_W-1).
- Gaps: pix_valid low for any number of cycles freezes counters, FSM, buffers and shift registers. Output resumes seamlessly.
- Back-to-back frames: the first pixel of frame N+1 may follow the last pixel of frame N on the next cycle. Stale buffer contents never reach a valid window because rows 0-1 are overwritten first.
- Reset mid-frame: the asynchronous clear applies immediately. The next accepted pixel is (0,0) of a new frame; no window is emitted until (2,2).

Optional Feature:
SOBEL_SOF_RESYNC_EN
- Defined: sof_in port exists. An accepted pixel with sof_in = 1 is forced to position (0,0): row and col are treated as 0, FSM = S_FILL, counters continue from (0,1). Any window owed from the aborted frame is not emitted, and win_last is not raised for it. sof_in without pix_valid is ignored.
- Undefined: no sof_in port; position tracking relies solely on counter wrap after reset.

Test Plan:
1. IMG_W=8, IMG_H=6, pixel value = row*16+col, continuous valid -> 24 windows. First window arrives the cycle after pixel 34 is accepted: p0=0, p1=1, p2=2, p3=16, p5=18, p6=32, p7=33, p8=34, win_last=0.
2. Same frame -> last window p0=53, p1=54, p2=55, p3=69, p5=71, p6=85, p7=86, p8=87, win_last=1. No win_valid for any pixel with col<2 or row<2.
3. Same frame with pix_valid low on every other cycle plus a 20-cycle gap mid-row 3 -> identical 24 windows in order, each exactly 1 cycle after its completing pixel.
4. Two frames back-to-back, frame 2 values = 255-(row*16+col) -> 48 windows total. Frame-2 first window: p0=255, p8=221. win_last pulses twice.
5. rst pulsed for 1 cycle after 30 pixels of a frame, then a full frame sent -> outputs 0 immediately on rst. Exactly 24 windows follow, first equal to scenario 1.
6. (SOBEL_SOF_RESYNC_EN) Send 13 pixels, then a full frame with sof_in=1 on its first pixel -> 24 windows matching scenario 1. No window is produced from the 13 orphan pixels.
